// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson-code receive checker.
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int              ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/johnson_code_classify.sv
// Combinational classifier: checks a Johnson word for legality and maps it to its step index.
module johnson_code_classify #(
  parameter int WIDTH = 4,
  localparam int IW = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IW-1:0]    index
);

  int unsigned k;

  always_comb begin
    legal = 1'b1;
    k     = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (code[i]) k++;
    end
    // MSB=1 words fill from the top down; MSB=0 words fill from the bottom up.
    if (code[WIDTH-1]) begin
      for (int unsigned i = 0; i < WIDTH-1; i++) begin
        if (code[i] && !code[i+1]) legal = 1'b0;
      end
      index = IW'(k - 1);
    end else begin
      for (int unsigned i = 1; i < WIDTH; i++) begin
        if (code[i] && !code[i-1]) legal = 1'b0;
      end
      index = IW'(2*WIDTH - 1 - k);
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code stream checker: tracks expected successor, locks after a run of matches,
// flags illegal/out-of-sequence words and keeps a saturating error count.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 2,
  parameter int UNLOCK_CNT = 2,
  localparam int IW = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [IW-1:0]    out_index,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int            MW   = $clog2(LOCK_CNT + 1);
  localparam int            NW   = $clog2(UNLOCK_CNT + 1);
  localparam logic [IW-1:0] LAST = IW'(2*WIDTH - 1);

  function automatic logic [IW-1:0] succ(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  logic          legal;
  logic [IW-1:0] idx;

  johnson_code_classify #(.WIDTH(WIDTH)) u_classify (
    .code  (in_code),
    .legal (legal),
    .index (idx)
  );

  state_t        state, state_n;
  logic [IW-1:0] expected, expected_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [NW-1:0] miss_cnt, miss_n;
  logic          code_err_n, seq_err_n, missed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      state     <= state_n;
      expected  <= expected_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
    end
  end

  always_comb begin
    state_n    = state;
    expected_n = expected;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    code_err_n = 1'b0;
    seq_err_n  = 1'b0;
    missed     = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (legal) begin
            expected_n = succ(idx);
            match_n    = MW'(1);
            miss_n     = '0;
            state_n    = (LOCK_CNT == 1) ? LOCKED : SYNC;
          end else begin
            code_err_n = 1'b1;
          end
        end
        SYNC: begin
          if (!legal) begin
            code_err_n = 1'b1;
            match_n    = '0;
            state_n    = HUNT;
          end else if (idx == expected) begin
            expected_n = succ(idx);
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end else begin
              match_n = match_cnt + 1'b1;
            end
          end else begin
            seq_err_n  = 1'b1;
            expected_n = succ(idx);
            match_n    = MW'(1);
          end
        end
        LOCKED: begin
          // An illegal word still consumes a slot, so expected steps forward blindly.
          if (!legal) begin
            code_err_n = 1'b1;
            expected_n = succ(expected);
            missed     = 1'b1;
          end else if (idx == expected) begin
            expected_n = succ(idx);
            miss_n     = '0;
          end else begin
            seq_err_n  = 1'b1;
            expected_n = succ(idx);
            missed     = 1'b1;
          end
          if (missed) begin
            if (miss_cnt == NW'(UNLOCK_CNT - 1)) begin
              state_n = HUNT;
              miss_n  = '0;
              match_n = '0;
            end else begin
              miss_n = miss_cnt + 1'b1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_index <= '0;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      out_valid <= in_valid;
      code_err  <= code_err_n;
      seq_err   <= seq_err_n;
      locked    <= (state_n == LOCKED);
      if (in_valid && legal) out_index <= idx;
      if (clr_err)
        err_count <= '0;
      else if ((code_err_n || seq_err_n) && err_count != ERR_MAX)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: directed Johnson words with hand-computed responses.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr_err;
  logic [3:0] in_code;
  logic       out_valid, code_err, seq_err, locked;
  logic [2:0] out_index;
  logic [7:0] err_count;

  johnson_decoder #(.WIDTH(4), .LOCK_CNT(2), .UNLOCK_CNT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .clr_err   (clr_err),
    .out_valid (out_valid),
    .out_index (out_index),
    .code_err  (code_err),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] code;
    logic [2:0] ix;
    logic       ce;
    logic       se;
    logic       lk;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_index"}, 32'(out_index), 0);
    chk({tag, "_code_err"},  32'(code_err),  0);
    chk({tag, "_seq_err"},   32'(seq_err),   0);
    chk({tag, "_locked"},    32'(locked),    0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  task automatic send(input logic [3:0] code, input logic [2:0] ix, input logic ce,
                      input logic se, input logic lk, input logic [7:0] ec,
                      input logic clr = 1'b0);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = code;
    clr_err  = clr;
    e.code = code; e.ix = ix; e.ce = ce; e.se = se; e.lk = lk; e.ec = ec;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  // Monitor: pops one expectation per presented output word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("out_index[%b]", e.code), 32'(out_index), 32'(e.ix));
          chk($sformatf("code_err[%b]",  e.code), 32'(code_err),  32'(e.ce));
          chk($sformatf("seq_err[%b]",   e.code), 32'(seq_err),   32'(e.se));
          chk($sformatf("locked[%b]",    e.code), 32'(locked),    32'(e.lk));
          chk($sformatf("err_count[%b]", e.code), 32'(err_count), 32'(e.ec));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] bad [4];
    bad[0] = 4'b1010; bad[1] = 4'b0100; bad[2] = 4'b1001; bad[3] = 4'b1101;
    rst = 1'b1; in_valid = 1'b0; in_code = '0; clr_err = 1'b0;
    #1;
    rst_chk("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Free-running sequence from 1000, locking after the second word, wrapping 7->0.
    send(4'b1000, 3'd0, 0, 0, 0, 8'd0);
    send(4'b1100, 3'd1, 0, 0, 1, 8'd0);
    send(4'b1110, 3'd2, 0, 0, 1, 8'd0);
    send(4'b1111, 3'd3, 0, 0, 1, 8'd0);
    send(4'b0111, 3'd4, 0, 0, 1, 8'd0);
    send(4'b0011, 3'd5, 0, 0, 1, 8'd0);
    send(4'b0001, 3'd6, 0, 0, 1, 8'd0);
    send(4'b0000, 3'd7, 0, 0, 1, 8'd0);
    send(4'b1000, 3'd0, 0, 0, 1, 8'd0);

    // Illegal word while locked: index holds, expected advances past it.
    send(4'b1010, 3'd0, 1, 0, 1, 8'd1);
    send(4'b1110, 3'd2, 0, 0, 1, 8'd1);
    send(4'b1111, 3'd3, 0, 0, 1, 8'd1);

    // Sequence jump, recovery, then two consecutive misses drop lock.
    send(4'b0011, 3'd5, 0, 1, 1, 8'd2);
    send(4'b0001, 3'd6, 0, 0, 1, 8'd2);
    send(4'b1100, 3'd1, 0, 1, 1, 8'd3);
    send(4'b1100, 3'd1, 0, 1, 0, 8'd4);

    // Relock, wrap 0000->1000 clean, then 0000->1100 is a sequence error.
    send(4'b0001, 3'd6, 0, 0, 0, 8'd4);
    send(4'b0000, 3'd7, 0, 0, 1, 8'd4);
    send(4'b1000, 3'd0, 0, 0, 1, 8'd4);
    send(4'b1100, 3'd1, 0, 0, 1, 8'd4);
    send(4'b1110, 3'd2, 0, 0, 1, 8'd4);
    send(4'b1111, 3'd3, 0, 0, 1, 8'd4);
    send(4'b0111, 3'd4, 0, 0, 1, 8'd4);
    send(4'b0011, 3'd5, 0, 0, 1, 8'd4);
    send(4'b0001, 3'd6, 0, 0, 1, 8'd4);
    send(4'b0000, 3'd7, 0, 0, 1, 8'd4);
    send(4'b1100, 3'd1, 0, 1, 1, 8'd5);
    send(4'b1110, 3'd2, 0, 0, 1, 8'd5);

    // 300 illegal words: lock lost on the second, count saturates at 255.
    for (int i = 0; i < 300; i++)
      send(bad[i % 4], 3'd2, 1, 0, (i == 0), (6 + i > 255) ? 8'd255 : 8'(6 + i));

    // clr_err coinciding with an error wins.
    send(4'b0101, 3'd2, 1, 0, 0, 8'd0, 1'b1);
    send(4'b0110, 3'd2, 1, 0, 0, 8'd1);

    // Resync and lock, then reset asynchronously between clock edges.
    send(4'b1000, 3'd0, 0, 0, 0, 8'd1);
    send(4'b1100, 3'd1, 0, 0, 1, 8'd1);
    send(4'b1110, 3'd2, 0, 0, 1, 8'd1);
    repeat (2) @(negedge clk);
    chk("locked_before_rst", 32'(locked), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    rst_chk("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // First word after release is taken in HUNT; lock needs LOCK_CNT words.
    send(4'b1111, 3'd3, 0, 0, 0, 8'd0);
    send(4'b0111, 3'd4, 0, 0, 1, 8'd0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
